// File: rtl/pll_seq_pkg.sv
// Shared state encoding, setting record and charge-pump / loop-filter table for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        LOCKED    = 3'd3,
        ERROR     = 3'd4
    } state_e;

    typedef struct packed {
        logic [5:0] icpsel;
        logic [2:0] lpfres;
    } setting_t;

    localparam int NumSettings = 4;
    localparam int IdxW        = $clog2(NumSettings);

    // Tried in order; each lock timeout steps to the next entry.
    localparam setting_t SETTINGS [NumSettings] = '{
        '{icpsel: 6'd8,  lpfres: 3'd2},
        '{icpsel: 6'd16, lpfres: 3'd3},
        '{icpsel: 6'd24, lpfres: 3'd4},
        '{icpsel: 6'd32, lpfres: 3'd5}
    };

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic setting_t setting_at(input logic [IdxW-1:0] idx);
        return SETTINGS[idx];
    endfunction

endpackage

// File: rtl/pll_seq_sync.sv
// Multi-flop synchroniser for the raw PLL lock; clears to 0 on asynchronous reset.
module pll_seq_sync #(
    parameter int Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: reset, lock qualification, setting retry and error give-up.
// Build option PLL_SEQ_RELOCK_EN: a lock loss while LOCKED re-runs the PLL reset instead of re-qualifying.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RstCycles    = 1000,
    parameter int LockTimeout  = 50000,
    parameter int StableCycles = 256,
    parameter int MaxRetries   = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       restart_i,
    input  logic       pll_lock_i,
    output logic       pll_rst_o,
    output logic [5:0] icpsel_o,
    output logic [2:0] lpfres_o,
    output logic       lock_o,
    output logic       error_o,
    output logic [3:0] attempt_o
);

    localparam int              CntW     = $clog2(max3(RstCycles, LockTimeout, StableCycles) + 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] RstLast  = CntW'(RstCycles - 1);
    localparam logic [CntW-1:0] ToLast   = CntW'(LockTimeout - 1);
    localparam logic [CntW-1:0] StabLast = CntW'(StableCycles - 1);
    localparam logic [3:0]      MaxAtt   = 4'(MaxRetries);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumSettings - 1);
    localparam logic [IdxW-1:0] IdxOne   = IdxW'(1);
    localparam setting_t        Set0     = SETTINGS[0];

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] stab_q, stab_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [3:0]      attempt_q, attempt_d;
    logic            pll_rst_q, pll_rst_d;
    logic            lock_q, lock_d;
    logic            error_q, error_d;
    logic [5:0]      icpsel_q, icpsel_d;
    logic [2:0]      lpfres_q, lpfres_d;
    logic            no_to_q, no_to_d;

    logic            lock_s;
    logic            qualify;
    logic            timeout_hit;
    logic [IdxW-1:0] idx_next;
    setting_t        next_set;

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (v == '1) ? v : v + CntOne;
    endfunction

    pll_seq_sync #(.Stages(2)) u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pll_lock_i),
        .q_o    (lock_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stab_d      = stab_q;
        idx_d       = idx_q;
        attempt_d   = attempt_q;
        pll_rst_d   = pll_rst_q;
        lock_d      = lock_q;
        error_d     = error_q;
        icpsel_d    = icpsel_q;
        lpfres_d    = lpfres_q;
        no_to_d     = no_to_q;
        qualify     = 1'b0;
        timeout_hit = 1'b0;
        idx_next    = (idx_q == IdxLast) ? '0 : idx_q + IdxOne;
        next_set    = setting_at(idx_next);

        case (state_q)
            RESET: begin
                pll_rst_d = 1'b1;
                if (cnt_q == RstLast) begin
                    state_d   = WAIT_LOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            WAIT_LOCK: begin
                if (!no_to_q) begin
                    cnt_d       = sat_inc(cnt_q);
                    timeout_hit = (cnt_q == ToLast);
                end
                if (lock_s) begin
                    state_d = STABLE;
                    stab_d  = '0;
                end
            end
            STABLE: begin
                // The timeout budget spans both WAIT_LOCK and STABLE, so it keeps running here.
                if (!no_to_q) begin
                    cnt_d       = sat_inc(cnt_q);
                    timeout_hit = (cnt_q == ToLast);
                end
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (stab_q == StabLast) begin
                    qualify = 1'b1;
                    state_d = LOCKED;
                    lock_d  = 1'b1;
                end else begin
                    stab_d = sat_inc(stab_q);
                end
            end
            LOCKED: begin
                if (!lock_s) begin
                    lock_d = 1'b0;
`ifdef PLL_SEQ_RELOCK_EN
                    state_d   = RESET;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    attempt_d = '0;
`else
                    state_d = STABLE;
                    stab_d  = '0;
                    no_to_d = 1'b1;
`endif
                end
            end
            ERROR: begin
                pll_rst_d = 1'b1;
                error_d   = 1'b1;
                lock_d    = 1'b0;
            end
            default: begin
                state_d = RESET;
            end
        endcase

        // A successful qualification in the same cycle beats the timeout.
        if (timeout_hit && !qualify) begin
            attempt_d = attempt_q + 4'd1;
            idx_d     = idx_next;
            cnt_d     = '0;
            stab_d    = '0;
            lock_d    = 1'b0;
            pll_rst_d = 1'b1;
            no_to_d   = 1'b0;
            if (attempt_d == MaxAtt) begin
                state_d = ERROR;
                error_d = 1'b1;
            end else begin
                state_d  = RESET;
                icpsel_d = next_set.icpsel;
                lpfres_d = next_set.lpfres;
            end
        end

        if (restart_i) begin
            state_d   = RESET;
            cnt_d     = '0;
            stab_d    = '0;
            idx_d     = '0;
            attempt_d = '0;
            error_d   = 1'b0;
            lock_d    = 1'b0;
            pll_rst_d = 1'b1;
            no_to_d   = 1'b0;
            icpsel_d  = Set0.icpsel;
            lpfres_d  = Set0.lpfres;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RESET;
            cnt_q     <= '0;
            stab_q    <= '0;
            idx_q     <= '0;
            attempt_q <= '0;
            pll_rst_q <= 1'b1;
            lock_q    <= 1'b0;
            error_q   <= 1'b0;
            icpsel_q  <= Set0.icpsel;
            lpfres_q  <= Set0.lpfres;
            no_to_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stab_q    <= stab_d;
            idx_q     <= idx_d;
            attempt_q <= attempt_d;
            pll_rst_q <= pll_rst_d;
            lock_q    <= lock_d;
            error_q   <= error_d;
            icpsel_q  <= icpsel_d;
            lpfres_q  <= lpfres_d;
            no_to_q   <= no_to_d;
        end
    end

    assign pll_rst_o = pll_rst_q;
    assign icpsel_o  = icpsel_q;
    assign lpfres_o  = lpfres_q;
    assign lock_o    = lock_q;
    assign error_o   = error_q;
    assign attempt_o = attempt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timings; edge counts are relative to reset release.
module tb_pll_lock_sequencer;

    logic       clk_i;
    logic       rst_ni;
    logic       restart_i;
    logic       pll_lock_i;
    logic       pll_rst_o;
    logic [5:0] icpsel_o;
    logic [2:0] lpfres_o;
    logic       lock_o;
    logic       error_o;
    logic [3:0] attempt_o;

    int n_cmp;
    int n_bad;

    pll_lock_sequencer #(
        .RstCycles    (4),
        .LockTimeout  (20),
        .StableCycles (3),
        .MaxRetries   (3)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .restart_i  (restart_i),
        .pll_lock_i (pll_lock_i),
        .pll_rst_o  (pll_rst_o),
        .icpsel_o   (icpsel_o),
        .lpfres_o   (lpfres_o),
        .lock_o     (lock_o),
        .error_o    (error_o),
        .attempt_o  (attempt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance n clock edges; returns just after the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Reset pulse; on return the next rising edge is edge 1.
    task automatic apply_reset(input logic lock_val);
        @(negedge clk_i);
        rst_ni     = 1'b0;
        restart_i  = 1'b0;
        pll_lock_i = lock_val;
        step(2);
        rst_ni = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t, want finish before 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen_lock;
        n_cmp      = 0;
        n_bad      = 0;
        rst_ni     = 1'b0;
        restart_i  = 1'b0;
        pll_lock_i = 1'b0;

        // Reset values
        step(2);
        check_eq("rst_pll_rst", 32'(pll_rst_o), 1);
        check_eq("rst_icpsel",  32'(icpsel_o),  8);
        check_eq("rst_lpfres",  32'(lpfres_o),  2);
        check_eq("rst_lock",    32'(lock_o),    0);
        check_eq("rst_error",   32'(error_o),   0);
        check_eq("rst_attempt", 32'(attempt_o), 0);

        // 1: clean lock, lock_i high from edge 8
        apply_reset(1'b0);
        step(3);
        check_eq("t1_pll_rst_e3", 32'(pll_rst_o), 1);
        step(1);
        check_eq("t1_pll_rst_e4", 32'(pll_rst_o), 0);
        step(3);
        pll_lock_i = 1'b1;
        step(5);
        check_eq("t1_lock_e12", 32'(lock_o), 0);
        step(1);
        check_eq("t1_lock_e13", 32'(lock_o), 1);
        check_eq("t1_icpsel",   32'(icpsel_o), 8);
        check_eq("t1_lpfres",   32'(lpfres_o), 2);

        // 4: one-cycle lock drop while LOCKED (continues from test 1)
        step(2);
        pll_lock_i = 1'b0;
        step(1);
        pll_lock_i = 1'b1;
        step(1);
        check_eq("t4_lock_e17", 32'(lock_o), 1);
        step(1);
        check_eq("t4_lock_e18", 32'(lock_o), 0);
`ifdef PLL_SEQ_RELOCK_EN
        check_eq("t4_pll_rst_e18", 32'(pll_rst_o), 1);
        step(3);
        check_eq("t4_pll_rst_e21", 32'(pll_rst_o), 1);
        check_eq("t4_icpsel",      32'(icpsel_o),  8);
        step(1);
        check_eq("t4_pll_rst_e22", 32'(pll_rst_o), 0);
        check_eq("t4_attempt",     32'(attempt_o), 0);
        step(4);
        check_eq("t4_relock_e26",  32'(lock_o),    1);
`else
        check_eq("t4_pll_rst_e18", 32'(pll_rst_o), 0);
        step(2);
        check_eq("t4_lock_e20",    32'(lock_o),    0);
        step(1);
        check_eq("t4_lock_e21",    32'(lock_o),    1);
        check_eq("t4_pll_rst_e21", 32'(pll_rst_o), 0);
        check_eq("t4_icpsel",      32'(icpsel_o),  8);
`endif

        // 2: no lock at all, walk the retry budget into ERROR
        apply_reset(1'b0);
        step(23);
        check_eq("t2_attempt_e23", 32'(attempt_o), 0);
        check_eq("t2_pll_rst_e23", 32'(pll_rst_o), 0);
        step(1);
        check_eq("t2_attempt_e24", 32'(attempt_o), 1);
        check_eq("t2_icpsel_e24",  32'(icpsel_o),  16);
        check_eq("t2_lpfres_e24",  32'(lpfres_o),  3);
        check_eq("t2_pll_rst_e24", 32'(pll_rst_o), 1);
        step(24);
        check_eq("t2_attempt_e48", 32'(attempt_o), 2);
        check_eq("t2_icpsel_e48",  32'(icpsel_o),  24);
        check_eq("t2_lpfres_e48",  32'(lpfres_o),  4);
        step(23);
        check_eq("t2_error_e71",   32'(error_o),   0);
        step(1);
        check_eq("t2_error_e72",   32'(error_o),   1);
        check_eq("t2_attempt_e72", 32'(attempt_o), 3);
        check_eq("t2_pll_rst_e72", 32'(pll_rst_o), 1);
        step(8);
        check_eq("t2_error_sticky", 32'(error_o),  1);
        check_eq("t2_pll_rst_hold", 32'(pll_rst_o), 1);
        restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        check_eq("t2_restart_error",   32'(error_o),   0);
        check_eq("t2_restart_icpsel",  32'(icpsel_o),  8);
        check_eq("t2_restart_lpfres",  32'(lpfres_o),  2);
        check_eq("t2_restart_attempt", 32'(attempt_o), 0);

        // 3: lock chatters 2 high / 2 low, never qualifies, timeout unaffected
        apply_reset(1'b0);
        seen_lock = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            pll_lock_i = ((k / 2) % 2) == 1;
            step(1);
            if (lock_o) seen_lock = 1'b1;
        end
        check_eq("t3_lock_never", 32'(seen_lock), 0);
        check_eq("t3_attempt",    32'(attempt_o), 1);
        check_eq("t3_pll_rst",    32'(pll_rst_o), 1);
        check_eq("t3_icpsel",     32'(icpsel_o),  16);

        // 5: restart on the same edge as the third timeout
        apply_reset(1'b0);
        step(71);
        check_eq("t5_icpsel_e71", 32'(icpsel_o), 24);
        restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        check_eq("t5_icpsel",  32'(icpsel_o),  8);
        check_eq("t5_attempt", 32'(attempt_o), 0);
        check_eq("t5_error",   32'(error_o),   0);
        check_eq("t5_pll_rst", 32'(pll_rst_o), 1);
        step(3);
        check_eq("t5_pll_rst_e75", 32'(pll_rst_o), 1);
        step(1);
        check_eq("t5_pll_rst_e76", 32'(pll_rst_o), 0);

        // 6: asynchronous reset in the middle of STABLE
        apply_reset(1'b1);
        step(6);
        check_eq("t6_pll_rst_pre", 32'(pll_rst_o), 0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("t6_pll_rst", 32'(pll_rst_o), 1);
        check_eq("t6_lock",    32'(lock_o),    0);
        check_eq("t6_icpsel",  32'(icpsel_o),  8);
        check_eq("t6_attempt", 32'(attempt_o), 0);
        check_eq("t6_error",   32'(error_o),   0);
        step(2);
        rst_ni = 1'b1;
        step(4);
        check_eq("t6_rerun_e4", 32'(pll_rst_o), 0);
        step(4);
        check_eq("t6_rerun_lock_e8", 32'(lock_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
